// File: rtl/tick_scheduler.sv
// tick_scheduler: run/pause/step FSM issuing 1-cycle clock-enable ticks every 2^DIVk cycles
// with a 16-bit running tick total.
module tick_scheduler #(
    parameter int DIV0      = 26,
    parameter int DIV1      = 24,
    parameter int DIV2      = 20,
    parameter int DIV3      = 17,
    parameter int CNT_WIDTH = 27
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        step,
    input  logic        clear,
    input  logic [1:0]  rate_sel,
    output logic        tick,
    output logic        running,
    output logic        paused,
    output logic [15:0] tick_total
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, STEP} state_t;

    state_t               state, state_n, ret;
    logic [1:0]           rate_q;
    logic [5:0]           div;
    logic [CNT_WIDTH-1:0] cnt, cnt_n, mask;
    logic                 tc, tick_n;

    // Terminal count looks only at the low DIVk bits, so a phase held across a rate change still wraps.
    always_comb begin
        div  = rate_q == 2'd0 ? 6'(DIV0) : rate_q == 2'd1 ? 6'(DIV1) : rate_q == 2'd2 ? 6'(DIV2) : 6'(DIV3);
        mask = ~({CNT_WIDTH{1'b1}} << div);
        tc   = (cnt & mask) == mask;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tick_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) state_n = RUN;
                else if (step) begin
                    state_n = STEP;
                    tick_n  = 1'b1;
                end
            end
            RUN: begin
                if (stop) state_n = PAUSE;
                else if (rate_sel != rate_q) cnt_n = '0;
                else begin
                    cnt_n  = tc ? '0 : cnt + 1'b1;
                    tick_n = tc;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (start) state_n = RUN;
                else if (step) begin
                    state_n = STEP;
                    tick_n  = 1'b1;
                end
            end
            default: state_n = ret;
        endcase
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            tick_n  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ret        <= IDLE;
            rate_q     <= 2'd0;
            cnt        <= '0;
            tick       <= 1'b0;
            running    <= 1'b0;
            paused     <= 1'b0;
            tick_total <= 16'd0;
        end else begin
            state      <= state_n;
            if (state != STEP) ret <= state;
            rate_q     <= rate_sel;
            cnt        <= cnt_n;
            tick       <= tick_n;
            running    <= state_n == RUN;
            paused     <= state_n == PAUSE;
            tick_total <= clear ? 16'd0 : tick_total + 16'(tick_n);
        end
    end
endmodule
